// File: rtl/audio_sample_scheduler.sv
// audio_sample_scheduler
// Gathers stereo samples into two ping-pong banks in the audio clock domain.
// A completed (or flushed) bank is handed to the pixel domain with a toggle
// handshake. Each stored sample also records whether it is IEC 60958 frame 0.
module audio_sample_scheduler #(
  parameter int AUDIO_BIT_WIDTH        = 16,
  parameter int MAX_SAMPLES_PER_PACKET = 2
) (
  input  logic                             clk_audio,
  input  logic                             audio_buffer_rst,
  input  logic                             sample_valid,
  input  logic [1:0][AUDIO_BIT_WIDTH-1:0]  audio_sample_word,
  input  logic                             flush_req_toggle,
  input  logic                             ack_toggle,
  output logic                             bank_ready_toggle,
  output logic [3:0][1:0][23:0]            bank_words,
  output logic [3:0]                       bank_present,
  output logic [3:0]                       bank_block_start,
  output logic [7:0]                       overflow_count
);

  localparam int         MAX   = MAX_SAMPLES_PER_PACKET;
  localparam logic [2:0] MAX_C = 3'(MAX);

  // Two banks of MAX stereo pairs, plus a frame-0 flag for every slot.
  logic [1:0][MAX-1:0][1:0][AUDIO_BIT_WIDTH-1:0] mem;
  logic [1:0][MAX-1:0]                           mem_bs;

  logic       fb;           // bank currently being filled
  logic       pb;           // bank last handed to the pixel domain
  logic [2:0] fc;           // pairs held in the fill bank
  logic [7:0] frame_index;  // IEC 60958 frame counter, 0..191
  logic       pending;      // published bank not yet acknowledged

  // Toggle synchronizers: two metastability flops, a third for edge history,
  // and a registered pulse so each request acts on the fourth edge.
  logic [2:0] flush_sync, ack_sync;
  logic       flush_pulse, ack_pulse;

  // Synchronize the pixel-domain toggles and turn each edge into a pulse.
  always_ff @(posedge clk_audio or posedge audio_buffer_rst) begin
    if (audio_buffer_rst) begin
      flush_sync  <= '0;
      ack_sync    <= '0;
      flush_pulse <= 1'b0;
      ack_pulse   <= 1'b0;
    end else begin
      flush_sync  <= {flush_sync[1:0], flush_req_toggle};
      ack_sync    <= {ack_sync[1:0], ack_toggle};
      flush_pulse <= flush_sync[1] ^ flush_sync[2];
      ack_pulse   <= ack_sync[1] ^ ack_sync[2];
    end
  end

  // An ack in the same cycle releases the old bank before a new publish.
  logic       pending_eff;
  logic       full;
  logic       publish;
  logic       accept;
  logic       drop;
  logic       wr_bank;
  logic [2:0] wr_slot;
  logic [3:0] present_mask;

  // Publish/accept/drop decisions for this cycle.
  always_comb begin
    pending_eff  = pending & ~ack_pulse;
    full         = (fc == MAX_C);
    publish      = !pending_eff && (full || (flush_pulse && fc != 3'd0));
    // A sample arriving with a publish lands in slot 0 of the new fill bank.
    accept       = sample_valid && (publish || !full);
    drop         = sample_valid && !publish && full;
    wr_bank      = publish ? ~fb : fb;
    wr_slot      = publish ? 3'd0 : fc;
    present_mask = 4'((5'd1 << fc) - 5'd1);
  end

  // Sample storage; left unreset because reads are masked by bank_present.
  always_ff @(posedge clk_audio) begin
    if (accept) begin
      for (int k = 0; k < MAX; k++) begin
        if (wr_slot == 3'(k)) begin
          mem[wr_bank][k]    <= audio_sample_word;
          mem_bs[wr_bank][k] <= (frame_index == 8'd0);
        end
      end
    end
  end

  // Bank bookkeeping, handshake and frame counting.
  always_ff @(posedge clk_audio or posedge audio_buffer_rst) begin
    if (audio_buffer_rst) begin
      fb                <= 1'b0;
      pb                <= 1'b0;
      fc                <= 3'd0;
      frame_index       <= 8'd0;
      pending           <= 1'b0;
      bank_ready_toggle <= 1'b0;
      bank_present      <= 4'd0;
      overflow_count    <= 8'd0;
    end else begin
      if (publish) begin
        pb                <= fb;
        fb                <= ~fb;
        pending           <= 1'b1;
        bank_present      <= present_mask;
        bank_ready_toggle <= ~bank_ready_toggle;
        fc                <= accept ? 3'd1 : 3'd0;
      end else begin
        pending <= pending_eff;
        if (accept) fc <= fc + 3'd1;
      end
      if (accept)
        frame_index <= (frame_index == 8'd191) ? 8'd0 : frame_index + 8'd1;
      if (drop && overflow_count != 8'hFF)
        overflow_count <= overflow_count + 8'd1;
    end
  end

  // Published view: bank pb, zero-extended to 24 bits, empty slots forced 0.
  for (genvar k = 0; k < 4; k++) begin : g_out
    if (k < MAX) begin : g_live
      assign bank_words[k][0]    = bank_present[k] ? 24'(mem[pb][k][0]) : 24'd0;
      assign bank_words[k][1]    = bank_present[k] ? 24'(mem[pb][k][1]) : 24'd0;
      assign bank_block_start[k] = bank_present[k] & mem_bs[pb][k];
    end else begin : g_zero
      assign bank_words[k]       = '0;
      assign bank_block_start[k] = 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Bench for audio_sample_scheduler: expected banks are queued as samples are
// driven and checked by a monitor every time bank_ready_toggle flips.
module tb_audio_sample_scheduler;
  localparam int W   = 16;
  localparam int MAX = 2;

  logic                 clk_audio = 1'b0;
  logic                 audio_buffer_rst = 1'b1;
  logic                 sample_valid = 1'b0;
  logic [1:0][W-1:0]    audio_sample_word = '0;
  logic                 flush_req_toggle = 1'b0;
  logic                 ack_toggle = 1'b0;
  logic                 bank_ready_toggle;
  logic [3:0][1:0][23:0] bank_words;
  logic [3:0]           bank_present;
  logic [3:0]           bank_block_start;
  logic [7:0]           overflow_count;

  audio_sample_scheduler #(.AUDIO_BIT_WIDTH(W), .MAX_SAMPLES_PER_PACKET(MAX)) dut (
    .clk_audio(clk_audio), .audio_buffer_rst(audio_buffer_rst),
    .sample_valid(sample_valid), .audio_sample_word(audio_sample_word),
    .flush_req_toggle(flush_req_toggle), .ack_toggle(ack_toggle),
    .bank_ready_toggle(bank_ready_toggle), .bank_words(bank_words),
    .bank_present(bank_present), .bank_block_start(bank_block_start),
    .overflow_count(overflow_count));

  always #5 clk_audio = ~clk_audio;

  typedef struct {
    logic [3:0]            present;
    logic [3:0]            bs;
    logic [3:0][1:0][23:0] words;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0, miscompares = 0, n_pub = 0;

  function automatic exp_t mk(input int n, input logic [15:0] l0, r0, l1, r1,
                              input logic [3:0] bs);
    exp_t e;
    e.words   = '0;
    e.present = (n == 2) ? 4'b0011 : 4'b0001;
    e.bs      = bs;
    e.words[0][0] = {8'h00, l0};
    e.words[0][1] = {8'h00, r0};
    if (n == 2) begin
      e.words[1][0] = {8'h00, l1};
      e.words[1][1] = {8'h00, r1};
    end
    return e;
  endfunction

  task automatic tick();
    @(negedge clk_audio);
    #1;
  endtask

  // Pops one expected bank per ready toggle and compares the published view.
  task automatic monitor();
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk_audio);
      if (audio_buffer_rst) begin
        prev = bank_ready_toggle;
      end else if (bank_ready_toggle !== prev) begin
        prev = bank_ready_toggle;
        n_pub++;
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_publish: present=%b, required no publish", bank_present);
        end else begin
          e = exp_q.pop_front();
          vectors += 3;
          if (bank_present !== e.present) begin
            miscompares++;
            $display("FAIL bank_present: got %b required %b", bank_present, e.present);
          end
          if (bank_block_start !== e.bs) begin
            miscompares++;
            $display("FAIL bank_block_start: got %b required %b", bank_block_start, e.bs);
          end
          if (bank_words !== e.words) begin
            miscompares++;
            $display("FAIL bank_words: got %h required %h", bank_words, e.words);
          end
        end
      end
    end
  endtask

  task automatic put(input logic [15:0] l, input logic [15:0] r);
    audio_sample_word[0] = l;
    audio_sample_word[1] = r;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_pub(input int target, input int budget, input string name);
    int i = 0;
    while (n_pub < target && i < budget) begin
      tick();
      i++;
    end
    vectors++;
    if (n_pub < target) begin
      miscompares++;
      $display("FAIL %s: publishes seen %0d, required %0d within %0d cycles", name, n_pub, target, budget);
    end
  endtask

  task automatic do_ack();
    ack_toggle = ~ack_toggle;
    repeat (6) tick();
  endtask

  task automatic do_reset();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_publish: %0d banks unpublished, required 0", exp_q.size());
    end
    exp_q.delete();
    audio_buffer_rst = 1'b1;
    sample_valid = 1'b0;
    flush_req_toggle = 1'b0;
    ack_toggle = 1'b0;
    repeat (3) tick();
    audio_buffer_rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    do_reset();
    vectors += 5;
    if (bank_ready_toggle !== 1'b0) begin miscompares++; $display("FAIL rst_toggle: got %b required 0", bank_ready_toggle); end
    if (bank_present !== 4'd0) begin miscompares++; $display("FAIL rst_present: got %b required 0000", bank_present); end
    if (bank_block_start !== 4'd0) begin miscompares++; $display("FAIL rst_bs: got %b required 0000", bank_block_start); end
    if (bank_words !== '0) begin miscompares++; $display("FAIL rst_words: got %h required 0", bank_words); end
    if (overflow_count !== 8'd0) begin miscompares++; $display("FAIL rst_overflow: got %0d required 0", overflow_count); end
  endtask

  task automatic test_full_bank();
    logic t0;
    t0 = bank_ready_toggle;
    exp_q.push_back(mk(2, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'b0001));
    put(16'h1111, 16'h2222);
    put(16'h3333, 16'h4444);
    vectors++;
    if (bank_ready_toggle !== t0) begin miscompares++; $display("FAIL full_early: toggle %b required %b", bank_ready_toggle, t0); end
    tick();
    vectors += 2;
    if (bank_ready_toggle !== ~t0) begin miscompares++; $display("FAIL full_latency: toggle %b required %b", bank_ready_toggle, ~t0); end
    if (bank_words[1][1] !== 24'h004444) begin miscompares++; $display("FAIL full_word11: got %h required 004444", bank_words[1][1]); end
    do_ack();
  endtask

  task automatic test_flush();
    logic t0;
    int base;
    t0 = bank_ready_toggle;
    base = n_pub;
    exp_q.push_back(mk(1, 16'hAAAA, 16'hBBBB, 16'h0, 16'h0, 4'b0000));
    put(16'hAAAA, 16'hBBBB);
    flush_req_toggle = ~flush_req_toggle;
    repeat (3) tick();
    vectors++;
    if (bank_ready_toggle !== t0) begin miscompares++; $display("FAIL flush_early: toggle %b required %b", bank_ready_toggle, t0); end
    tick();
    vectors++;
    if (bank_ready_toggle !== ~t0) begin miscompares++; $display("FAIL flush_latency: toggle %b required %b", bank_ready_toggle, ~t0); end
    // Flush while pending: dropped, not queued.
    put(16'hCCCC, 16'hDDDD);
    flush_req_toggle = ~flush_req_toggle;
    repeat (8) tick();
    vectors++;
    if (n_pub !== base + 1) begin miscompares++; $display("FAIL flush_pending: publishes %0d required %0d", n_pub, base + 1); end
    do_ack();
    vectors++;
    if (n_pub !== base + 1) begin miscompares++; $display("FAIL flush_not_queued: publishes %0d required %0d", n_pub, base + 1); end
    exp_q.push_back(mk(1, 16'hCCCC, 16'hDDDD, 16'h0, 16'h0, 4'b0000));
    flush_req_toggle = ~flush_req_toggle;
    wait_pub(base + 2, 8, "flush_second");
    do_ack();
  endtask

  task automatic test_overflow();
    int base;
    base = n_pub;
    exp_q.push_back(mk(2, 16'h5000, 16'h5001, 16'h5002, 16'h5003, 4'b0000));
    exp_q.push_back(mk(2, 16'h6000, 16'h6001, 16'h6002, 16'h6003, 4'b0000));
    put(16'h5000, 16'h5001);
    put(16'h5002, 16'h5003);
    wait_pub(base + 1, 4, "ovf_first");
    repeat (2) tick();
    put(16'h6000, 16'h6001);
    put(16'h6002, 16'h6003);
    for (int i = 0; i < 3; i++) put(16'h7000 + 16'(i), 16'h7100);
    vectors += 2;
    if (overflow_count !== 8'd3) begin miscompares++; $display("FAIL ovf_count: got %0d required 3", overflow_count); end
    if (n_pub !== base + 1) begin miscompares++; $display("FAIL ovf_held: publishes %0d required %0d", n_pub, base + 1); end
    ack_toggle = ~ack_toggle;
    wait_pub(base + 2, 5, "ovf_after_ack");
    do_ack();
  endtask

  task automatic test_back_to_back();
    int base;
    base = n_pub;
    exp_q.push_back(mk(2, 16'h8000, 16'h8001, 16'h8002, 16'h8003, 4'b0000));
    exp_q.push_back(mk(2, 16'h8004, 16'h8005, 16'h8006, 16'h8007, 4'b0000));
    put(16'h8000, 16'h8001);
    put(16'h8002, 16'h8003);
    put(16'h8004, 16'h8005);  // lands on the publish edge
    vectors += 2;
    if (n_pub !== base + 1) begin miscompares++; $display("FAIL b2b_publish: publishes %0d required %0d", n_pub, base + 1); end
    if (overflow_count !== 8'd3) begin miscompares++; $display("FAIL b2b_no_drop: overflow %0d required 3", overflow_count); end
    put(16'h8006, 16'h8007);
    repeat (2) tick();
    ack_toggle = ~ack_toggle;
    wait_pub(base + 2, 6, "b2b_second");
    do_ack();
  endtask

  task automatic test_frame_wrap();
    int base;
    logic [3:0] bs;
    do_reset();
    base = n_pub;
    for (int b = 0; b < 97; b++) begin
      bs = {2'b00, ((2 * b + 1) % 192) == 0, ((2 * b) % 192) == 0};
      exp_q.push_back(mk(2, 16'(2 * b), 16'(2 * b) ^ 16'hF000,
                         16'(2 * b + 1), 16'(2 * b + 1) ^ 16'hF000, bs));
      put(16'(2 * b), 16'(2 * b) ^ 16'hF000);
      put(16'(2 * b + 1), 16'(2 * b + 1) ^ 16'hF000);
      wait_pub(base + b + 1, 4, "wrap_publish");
      ack_toggle = ~ack_toggle;
      repeat (5) tick();
    end
    vectors++;
    if (overflow_count !== 8'd0) begin miscompares++; $display("FAIL wrap_overflow: got %0d required 0", overflow_count); end
  endtask

  task automatic test_reset_mid();
    int base;
    base = n_pub;
    // Frame index is 2 here (194 samples since reset).
    exp_q.push_back(mk(2, 16'h9000, 16'h9001, 16'h9002, 16'h9003, 4'b0000));
    put(16'h9000, 16'h9001);
    put(16'h9002, 16'h9003);
    wait_pub(base + 1, 4, "mid_first");
    for (int i = 0; i < 9; i++) put(16'hA000 + 16'(i), 16'hA100);
    vectors++;
    if (overflow_count !== 8'd7) begin miscompares++; $display("FAIL mid_overflow: got %0d required 7", overflow_count); end
    #2 audio_buffer_rst = 1'b1;
    #1;
    vectors += 5;
    if (bank_ready_toggle !== 1'b0) begin miscompares++; $display("FAIL mid_toggle: got %b required 0", bank_ready_toggle); end
    if (bank_present !== 4'd0) begin miscompares++; $display("FAIL mid_present: got %b required 0000", bank_present); end
    if (bank_block_start !== 4'd0) begin miscompares++; $display("FAIL mid_bs: got %b required 0000", bank_block_start); end
    if (bank_words !== '0) begin miscompares++; $display("FAIL mid_words: got %h required 0", bank_words); end
    if (overflow_count !== 8'd0) begin miscompares++; $display("FAIL mid_overflow_rst: got %0d required 0", overflow_count); end
    do_reset();
    base = n_pub;
    exp_q.push_back(mk(2, 16'hB000, 16'hB001, 16'hB002, 16'hB003, 4'b0001));
    put(16'hB000, 16'hB001);
    put(16'hB002, 16'hB003);
    wait_pub(base + 1, 4, "mid_after_reset");
    do_ack();
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_full_bank();
    test_flush();
    test_overflow();
    test_back_to_back();
    test_frame_wrap();
    test_reset_mid();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_banks: %0d unpublished, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
